// File: rtl/day3_pkg.sv
`default_nettype none
// ============================================================================
// day3_pkg
// Shared constants and types for the day-3 joltage pipeline.
// Rev 1.0
// ============================================================================
package day3_pkg;

    localparam int DEF_MAX_DIGITS = 100;
    localparam int DEF_LEN_W      = 7;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        WAIT_OUT = 2'd1,
        DONE     = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;

endpackage
`default_nettype wire

// File: rtl/bank_row_slot.sv
`default_nettype none
// ============================================================================
// bank_row_slot
// Output row register with valid/ready handshake and accepted-row counter.
// Rev 1.0
// ============================================================================
module bank_row_slot #(
    parameter int DATA_W = 400,
    parameter int LEN_W  = 7,
    parameter int LINE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_digits,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              out_ready,
    output logic              slot_free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_digits,
    output logic [LEN_W-1:0]  out_len,
    output logic [LINE_W-1:0] line_count
);

    logic              r_valid;
    logic [DATA_W-1:0] r_digits;
    logic [LEN_W-1:0]  r_len;
    logic [LINE_W-1:0] r_line_count;
    logic              w_pop;

    assign w_pop     = r_valid && out_ready;
    // A load may coincide with a pop, giving bubble-free back-to-back rows.
    assign slot_free = !r_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_digits     <= '0;
            r_len        <= '0;
            r_line_count <= '0;
        end else begin
            if (load) begin
                r_valid  <= 1'b1;
                r_digits <= load_digits;
                r_len    <= load_len;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (w_pop) begin
                r_line_count <= r_line_count + LINE_W'(1);
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_digits = r_digits;
    assign out_len    = r_len;
    assign line_count = r_line_count;

endmodule
`default_nettype wire

// File: rtl/ascii_bank_packer.sv
`default_nettype none
// ============================================================================
// ascii_bank_packer
// Packs ASCII digit lines into BCD bank rows behind a one-row output slot.
// Rev 1.0
// ============================================================================
module ascii_bank_packer
    import day3_pkg::*;
#(
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int LINE_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MAX_DIGITS*4-1:0] out_digits,
    output logic [LEN_W-1:0]        out_len,
    output logic [LINE_W-1:0]       line_count,
    output logic                    overflow,
    output logic                    bad_char,
    output logic                    done
);

    localparam int               C_ROW_W   = MAX_DIGITS * 4;
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_DIGITS);

    state_t             r_state, w_state_n;
    logic [C_ROW_W-1:0] r_row, w_row_n;
    logic [LEN_W-1:0]   r_count, w_count_n;
    logic               r_last, w_last_n;
    logic               r_overflow, r_bad_char;
    logic               w_accept, w_is_digit, w_is_lf, w_is_cr;
    logic               w_term, w_full, w_load, w_slot_free;
    digit_t             w_digit;

    assign in_ready   = (r_state == COLLECT) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    assign w_is_lf    = (in_data == CH_LF);
    assign w_is_cr    = (in_data == CH_CR);
    // ASCII '0'..'9' carry their BCD value in the low nibble.
    assign w_digit    = in_data[3:0];
    assign w_full     = (r_count >= C_MAX_LEN);
    assign w_term     = w_accept && (w_is_lf || in_last);

    always_comb begin
        w_row_n   = r_row;
        w_count_n = r_count;
        w_state_n = r_state;
        w_last_n  = r_last;
        w_load    = 1'b0;

        if (w_accept && w_is_digit && !w_full) begin
            for (int k = 0; k < MAX_DIGITS; k++) begin
                if (r_count == LEN_W'(k)) begin
                    w_row_n[k*4 +: 4] = w_digit;
                end
            end
            w_count_n = r_count + LEN_W'(1);
        end

        // WAIT_OUT with an empty assembly row means only the slot drain is pending.
        case (r_state)
            COLLECT: begin
                if (w_term) begin
                    w_last_n = in_last;
                    if (w_count_n != '0) begin
                        if (w_slot_free) begin
                            w_load    = 1'b1;
                            w_state_n = in_last ? WAIT_OUT : COLLECT;
                        end else begin
                            w_state_n = WAIT_OUT;
                        end
                    end else if (in_last) begin
                        w_state_n = w_slot_free ? DONE : WAIT_OUT;
                    end
                end
            end
            WAIT_OUT: begin
                if (w_slot_free) begin
                    if (r_count != '0) begin
                        w_load    = 1'b1;
                        w_state_n = r_last ? WAIT_OUT : COLLECT;
                    end else begin
                        w_state_n = r_last ? DONE : COLLECT;
                    end
                end
            end
            DONE:    w_state_n = DONE;
            default: w_state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_row      <= '0;
            r_count    <= '0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
            r_bad_char <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_last  <= w_last_n;
            if (w_load) begin
                r_row   <= '0;
                r_count <= '0;
            end else begin
                r_row   <= w_row_n;
                r_count <= w_count_n;
            end
            if (w_accept && w_is_digit && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_accept && !w_is_digit && !w_is_lf && !w_is_cr) begin
                r_bad_char <= 1'b1;
            end
        end
    end

    bank_row_slot #(
        .DATA_W (C_ROW_W),
        .LEN_W  (LEN_W),
        .LINE_W (LINE_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load        (w_load),
        .load_digits (w_row_n),
        .load_len    (w_count_n),
        .out_ready   (out_ready),
        .slot_free   (w_slot_free),
        .out_valid   (out_valid),
        .out_digits  (out_digits),
        .out_len     (out_len),
        .line_count  (line_count)
    );

    assign overflow = r_overflow;
    assign bad_char = r_bad_char;
    assign done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/ascii_bank_packer.md
Name: ascii_bank_packer

Overview:
Upstream front-end for the day-3 joltage stage. Consumes the raw puzzle input as an ASCII byte stream and assembles each text line of digits into one packed BCD bank row. Emits each row with its digit count over a valid/ready handshake to the bank-evaluation stage. Double-buffered (assembly row plus output slot), so byte intake continues while the consumer stalls on the previous row.

Parameters:
MAX_DIGITS, 100, maximum digits per bank row; the output bus is MAX_DIGITS*4 bits wide.
LEN_W, 7, width of the digit count; must satisfy 2^LEN_W > MAX_DIGITS.
LINE_W, 8, width of the emitted-line counter.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  byte on in_data is valid
in_ready  out  1  packer accepts the byte this cycle
in_data  in  8  ASCII byte
in_last  in  1  marks the final byte of the file; qualified by in_valid&&in_ready
out_valid  out  1  out_digits/out_len hold a complete row
out_ready  in  1  consumer accepts the row
out_digits  out  MAX_DIGITS*4  BCD digits; nibble k = k-th digit from the left of the line; unused nibbles are 0
out_len  out  LEN_W  number of valid digits, 1..MAX_DIGITS
line_count  out  LINE_W  rows accepted by the consumer; wraps modulo 2^LINE_W
overflow  out  1  sticky: some line exceeded MAX_DIGITS
bad_char  out  1  sticky: a byte was neither a digit, LF nor CR
done  out  1  stream fully consumed and last row accepted

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_digits=0, out_len=0, line_count=0, overflow=0, bad_char=0, done=0. Assembly row and count cleared; FSM to COLLECT. Reset mid-stream discards any partial row and any pending row.
- FSM states:
  - COLLECT: in_ready=1.
  - WAIT_OUT: in_ready=0; a completed assembly row waits for the output slot.
  - DONE: in_ready=0, done=1.
- Byte accept: occurs on in_valid && in_ready.
- Digit '0'..'9' (0x30-0x39):
  - If count < MAX_DIGITS: write (byte-0x30) into nibble[count], then count+1.
  - Otherwise drop the digit and set overflow.
- CR (0x0D): ignored.
- Any other byte except LF: ignored, and bad_char set.
- Terminator: LF (0x0A), or any accepted byte with in_last=1. For in_last, a digit on that byte is absorbed first.
- On terminator with count=0: no row is emitted (blank lines are skipped).
- On terminator with count>0, the slot is free if !out_valid || out_ready in the same cycle:
  - Slot free: load the assembly row into the slot the same cycle. out_valid rises on the next edge; latency is 1 cycle from the terminator byte. Assembly and count clear.
  - Slot not free: go to WAIT_OUT. The row is held intact.
- WAIT_OUT: when the slot frees, load the row. Go to DONE if the terminator had in_last, else COLLECT.
- in_last terminator with nothing pending: go to DONE once out_valid=0 or the final row is accepted. done is asserted only when no row remains in the slot.
- Output handshake:
  - out_digits and out_len are stable while out_valid && !out_ready.
  - On out_valid && out_ready, line_count increments.
  - out_valid drops unless a new row loads in the same cycle. Back-to-back pop and load is allowed with no bubble.
- Sticky flags clear only on rst.
- DONE is terminal until rst; bytes are not accepted.

Decomposition:
- Shared package day3_pkg holds:
  - ASCII constants: CH_0, CH_9, CH_LF, CH_CR.
  - Defaults MAX_DIGITS=100 and LEN_W=7.
  - FSM state typedef {COLLECT, WAIT_OUT, DONE}.
  - Digit-nibble typedef, also used by the downstream evaluation stage.
- One natural sub-module, bank_row_slot: the output register with valid/ready, load and pop, and the line_count increment. The assembly logic and FSM stay in the top.

Test Plan:
- Bytes "987654321111111\n", out_ready=1 → one row: out_len=15, nibble0=9, nibble1=8, nibble14=1, nibbles 15+ =0; out_valid 1 cycle after LF; line_count=1.
- Lines "12\n34\n56\n" with out_ready=0 until the 3rd LF is presented → in_ready drops at the 2nd LF (WAIT_OUT). Raising out_ready yields rows 12, 34, 56 in order; no loss; line_count=3.
- "\r\n\n818181\r\n" → exactly one row, len=6, digits 8,1,8,1,8,1; bad_char=0.
- A 102-digit line with MAX_DIGITS=100 → out_len=100, the last two digits dropped, overflow=1 and remains 1 through the next line.
- "42x7" with in_last on '7' → row len=3, digits 4,2,7; bad_char=1; done=1 one cycle after row acceptance; in_ready stays 0.
- rst asserted mid-line after "55" → all outputs at reset values. The next "3\n" yields len=1, digit 3; line_count=1.
